// File: rtl/prio_q_pkg.sv
// Shared constants, FSM encoding and element ordering for the prio_q client controller.
package prio_q_pkg;
    localparam int DWIDTH = 32;
    localparam int HDEPTH = 5;
    localparam int CAP    = (1 << HDEPTH) - 1;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    // Smaller unsigned value means higher priority.
    function automatic logic elem_lt(input logic [DWIDTH-1:0] a, input logic [DWIDTH-1:0] b);
        return a < b;
    endfunction
endpackage

// File: rtl/prio_q_ctrl.sv
// Client-side controller for the prio_q heap: arbitrates inserts against refills and keeps
// the global minimum of everything it owns in a single output register.
module prio_q_ctrl
    import prio_q_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_data,
    input  logic              flush,
    output logic              flush_done,
    output logic [HDEPTH:0]   occupancy,
    output logic              cnt_err,
    output logic              pq_enq,
    output logic              pq_deq,
    output logic [DWIDTH-1:0] pq_inp_data,
    input  logic [DWIDTH-1:0] pq_out_data,
    input  logic [HDEPTH-1:0] pq_elem_cnt
);
    localparam logic [HDEPTH-1:0] CNT_MAX = HDEPTH'(CAP);

    state_t            r_state;
    state_t            w_state_next;
    logic              r_out_valid;
    logic [DWIDTH-1:0] r_out_data;
    logic [HDEPTH-1:0] r_cnt;
    logic              r_fair;
    logic              r_flush_done;
    logic              r_cnt_err;
    logic              r_prev_op;

    logic w_cnt_zero;
    logic w_free;
    logic w_refill;
    logic w_bypass;
    logic w_swap;
    logic w_accept;

    assign w_cnt_zero = (r_cnt == '0);
    assign w_free     = !r_out_valid || out_ready;
    // After a refill, a waiting insert gets the next slot so it cannot be starved.
    assign w_refill   = w_free && !w_cnt_zero && !(r_fair && in_valid);
    assign w_bypass   = w_cnt_zero && w_free;
    assign w_swap     = r_out_valid && !out_ready && elem_lt(in_data, r_out_data);
    assign w_accept   = in_valid && in_ready;

    assign pq_inp_data = w_swap ? r_out_data : in_data;
    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign flush_done  = r_flush_done;
    assign cnt_err     = r_cnt_err;
    assign occupancy   = {1'b0, r_cnt} + {{HDEPTH{1'b0}}, r_out_valid};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RUN:   if (flush) w_state_next = FLUSH;
            FLUSH: if (w_cnt_zero) w_state_next = RUN;
        endcase
    end

    always_comb begin
        pq_enq   = 1'b0;
        pq_deq   = 1'b0;
        in_ready = 1'b0;
        if (!rst) begin
            case (r_state)
                RUN: begin
                    if (!flush) begin
                        if (w_refill) begin
                            pq_deq = 1'b1;
                        end else begin
                            // A full heap refuses even a swap: the displaced element needs a slot.
                            in_ready = w_bypass || (r_cnt < CNT_MAX);
                            pq_enq   = in_valid && !w_bypass && (r_cnt < CNT_MAX);
                        end
                    end
                end
                FLUSH: pq_deq = !w_cnt_zero;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_cnt        <= '0;
            r_fair       <= 1'b0;
            r_flush_done <= 1'b0;
            r_cnt_err    <= 1'b0;
            r_prev_op    <= 1'b0;
        end else begin
            r_flush_done <= 1'b0;
            r_prev_op    <= pq_enq || pq_deq;
            // The heap count may lag one cycle behind an operation, so only compare when quiet.
            if (!r_prev_op && (r_cnt != pq_elem_cnt)) begin
                r_cnt_err <= 1'b1;
            end
            case (r_state)
                RUN: begin
                    if (flush) begin
                        r_out_valid <= 1'b0;
                    end else if (w_refill) begin
                        r_out_data  <= pq_out_data;
                        r_out_valid <= 1'b1;
                        r_cnt       <= r_cnt - 1'b1;
                        r_fair      <= 1'b1;
                    end else if (w_accept) begin
                        r_fair <= 1'b0;
                        if (w_bypass) begin
                            r_out_data  <= in_data;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                            if (w_swap) begin
                                r_out_data <= in_data;
                            end else if (w_free) begin
                                r_out_valid <= 1'b0;
                            end
                        end
                    end else if (r_out_valid && out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                FLUSH: begin
                    if (w_cnt_zero) begin
                        r_flush_done <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_prio_q_ctrl.sv
// Directed bench for prio_q_ctrl with a behavioural heap model and an output scoreboard.
module tb_prio_q_ctrl;
    import prio_q_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DWIDTH-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DWIDTH-1:0] out_data;
    logic              flush;
    logic              flush_done;
    logic [HDEPTH:0]   occupancy;
    logic              cnt_err;
    logic              pq_enq;
    logic              pq_deq;
    logic [DWIDTH-1:0] pq_inp_data;
    logic [DWIDTH-1:0] pq_out_data;
    logic [HDEPTH-1:0] pq_elem_cnt;

    prio_q_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .flush       (flush),
        .flush_done  (flush_done),
        .occupancy   (occupancy),
        .cnt_err     (cnt_err),
        .pq_enq      (pq_enq),
        .pq_deq      (pq_deq),
        .pq_inp_data (pq_inp_data),
        .pq_out_data (pq_out_data),
        .pq_elem_cnt (pq_elem_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_enq   = 0;
    int n_both  = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_val;
    logic        last_enq;
    logic [31:0] last_inp;

    // Heap model: sorted queue, ops sampled mid-cycle and applied at the edge.
    logic [31:0] pq_model[$];
    logic        op_enq = 1'b0;
    logic        op_deq = 1'b0;
    logic [31:0] op_data = '0;

    always @(negedge clk) begin
        op_enq  = pq_enq && !rst;
        op_deq  = pq_deq && !rst;
        op_data = pq_inp_data;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pq_model.delete();
        end else begin
            if (op_deq && pq_model.size() > 0) begin
                void'(pq_model.pop_front());
            end
            if (op_enq) begin
                int idx;
                idx = pq_model.size();
                for (int k = 0; k < pq_model.size(); k++) begin
                    if (pq_model[k] > op_data) begin
                        idx = k;
                        break;
                    end
                end
                pq_model.insert(idx, op_data);
            end
        end
        pq_elem_cnt <= HDEPTH'(pq_model.size());
        pq_out_data <= (pq_model.size() > 0) ? pq_model[0] : '0;
    end

    // Scoreboard monitor: every handshake that will occur at the next edge is checked here.
    always @(negedge clk) begin
        if (!rst) begin
            if (pq_enq) n_enq++;
            if (pq_enq && pq_deq) n_both++;
            if (out_valid && out_ready) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_pop: got %0d, expected no output", out_data);
                end else begin
                    exp_val = exp_q.pop_front();
                    if (out_data !== exp_val) begin
                        n_fail++;
                        $display("FAIL sb_pop: got %0d, expected %0d", out_data, exp_val);
                    end else begin
                        $display("[TB] pop %0d ok", out_data);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            $display("[TB] %s = %0d ok", name, act);
        end
    endtask

    task automatic send(input logic [31:0] v, output int waited);
        in_valid = 1'b1;
        in_data  = v;
        waited   = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 60) begin
                n_tests++;
                n_fail++;
                $display("FAIL send_timeout: value %0d not accepted, expected acceptance", v);
                break;
            end
        end
        last_enq = pq_enq;
        last_inp = pq_inp_data;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        out_ready = 1'b1;
        for (int c = 0; c < 80; c++) begin
            @(posedge clk);
            #1;
            if (occupancy == 0) break;
        end
        out_ready = 1'b0;
        chk(name, 32'(occupancy), 32'd0);
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int deqs;
        int seen;
        rst = 1'b1;
        in_valid = 1'b1;
        in_data = 32'd9;
        out_ready = 1'b1;
        flush = 1'b0;
        #12;
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_pq_enq", 32'(pq_enq), 0);
        chk("rst_pq_deq", 32'(pq_deq), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_occupancy", 32'(occupancy), 0);
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Bypass into an empty controller.
        send(32'd40, w);
        chk("bypass_out_valid", 32'(out_valid), 1);
        chk("bypass_out_data", out_data, 40);
        chk("bypass_occupancy", 32'(occupancy), 1);
        chk("bypass_no_enq", n_enq, 0);

        // Swap a smaller value in, then an equal value must not swap.
        send(32'd25, w);
        chk("swap_enq", 32'(last_enq), 1);
        chk("swap_inp_data", last_inp, 40);
        chk("swap_out_data", out_data, 25);
        chk("swap_occupancy", 32'(occupancy), 2);
        send(32'd25, w);
        chk("tie_enq", 32'(last_enq), 1);
        chk("tie_inp_data", last_inp, 25);
        chk("tie_out_data", out_data, 25);
        exp_q.push_back(25); exp_q.push_back(25); exp_q.push_back(40);
        drain("swap_drain_empty");

        // Ordering.
        exp_q.push_back(10); exp_q.push_back(20); exp_q.push_back(30);
        exp_q.push_back(40); exp_q.push_back(50);
        send(32'd50, w); send(32'd10, w); send(32'd30, w); send(32'd20, w); send(32'd40, w);
        chk("order_occupancy", 32'(occupancy), 5);
        drain("order_drain_empty");
        chk("order_enq_deq_exclusive", n_both, 0);

        // Fairness: pending insert must get a slot right after one refill.
        for (int i = 1; i <= 11; i++) begin
            send(32'(i), w);
            exp_q.push_back(32'(i));
        end
        exp_q.push_back(99);
        out_ready = 1'b1;
        send(32'd99, w);
        chk("fair_wait_cycles", w, 1);
        drain("fair_drain_empty");

        // Full heap.
        for (int i = 0; i < 32; i++) send(32'(100 + i), w);
        chk("full_occupancy", 32'(occupancy), 32);
        exp_q.push_back(100);
        in_valid = 1'b1;
        in_data = 32'd5;
        @(negedge clk);
        chk("full_refuse_swap", 32'(in_ready), 0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("full_refill_ready", 32'(in_ready), 0);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("full_reenable", 32'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        exp_q.push_back(5);
        for (int i = 1; i < 32; i++) exp_q.push_back(32'(100 + i));
        drain("full_drain_empty");

        // Flush with 7 in the heap and one held.
        for (int i = 0; i < 8; i++) send(32'(60 + i), w);
        chk("flush_pre_occupancy", 32'(occupancy), 8);
        pulse_flush();
        chk("flush_drop_out_valid", 32'(out_valid), 0);
        deqs = 0;
        seen = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (pq_deq) deqs++;
            if (flush_done) begin
                seen = 1;
                break;
            end
        end
        chk("flush_deq_cycles", deqs, 7);
        chk("flush_done_seen", seen, 1);
        chk("flush_occupancy", 32'(occupancy), 0);
        @(negedge clk);
        chk("flush_done_single", 32'(flush_done), 0);
        @(posedge clk);
        #1;

        // Reset in the middle of a flush.
        for (int i = 0; i < 8; i++) send(32'(70 + i), w);
        pulse_flush();
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("midrst_occupancy", 32'(occupancy), 0);
        chk("midrst_pq_deq", 32'(pq_deq), 0);
        chk("midrst_flush_done", 32'(flush_done), 0);
        chk("midrst_cnt_err", 32'(cnt_err), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_cnt_err", 32'(cnt_err), 0);
        exp_q.push_back(7);
        send(32'd7, w);
        chk("post_rst_bypass", out_data, 7);
        drain("post_rst_drain_empty");
        chk("sb_all_consumed", 32'(exp_q.size()), 0);
        chk("final_cnt_err", 32'(cnt_err), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/prio_q_ctrl.md
Name: prio_q_ctrl

Overview:
- Initiator/client side of the prio_q heap interface. Drives prio_q's enq/deq/inp_data pins and consumes out_data/elem_cnt.
- Presents a valid/ready insert stream upstream (event generator) and a valid/ready min-element stream downstream (event dispatcher to cores).
- Holds one popped element in an output register and guarantees that element is always the global minimum of everything it owns.

Parameters:
- DWIDTH, 32, element width. Whole word is compared unsigned; smaller value = higher priority.
- HDEPTH, 5, prio_q depth parameter. Heap capacity CAP = 2^HDEPTH - 1 = 31.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- in_valid  in  1  insert request
- in_ready  out  1  insert accepted when in_valid && in_ready at posedge
- in_data  in  DWIDTH  element to insert
- out_valid  out  1  output register holds the current minimum
- out_ready  in  1  consumer takes out_data at posedge when out_valid
- out_data  out  DWIDTH  current minimum element
- flush  in  1  one-cycle pulse: discard all contents
- flush_done  out  1  one-cycle pulse when flush completes
- occupancy  out  HDEPTH+1  mirror count + out_valid
- cnt_err  out  1  sticky: mirror count != pq_elem_cnt
- pq_enq  out  1  to prio_q enq
- pq_deq  out  1  to prio_q deq
- pq_inp_data  out  DWIDTH  to prio_q inp_data
- pq_out_data  in  DWIDTH  prio_q root; valid in any cycle deq is asserted
- pq_elem_cnt  in  HDEPTH  prio_q element count

Behaviour:
- Reset values: out_valid=0, out_data=0, flush_done=0, cnt_err=0, mirror cnt=0, state=RUN, fair=0.
- Reset values, combinational outputs: pq_enq, pq_deq and in_ready are 0 while rst is high.
- pq_enq, pq_deq and in_ready are combinational from registered state and inputs. pq_enq and pq_deq are never both asserted in one cycle.
- States: RUN and FLUSH.
- RUN definitions:
  - free = !out_valid || out_ready.
  - refill = free && cnt>0 && !(fair && in_valid).
- RUN, refill: pq_deq=1, in_ready=0. out_data<=pq_out_data, out_valid<=1, cnt--, fair<=1.
- RUN, otherwise, in_ready is asserted when either:
  - cnt==0 && free (bypass), or
  - cnt<CAP.
- RUN, on an accepted insert:
  - Bypass (cnt==0 && free): out_data<=in_data, out_valid<=1. No pq op.
  - Swap (out_valid && !out_ready && in_data < out_data): pq_enq=1 with pq_inp_data=out_data, then out_data<=in_data, cnt++.
  - Otherwise: pq_enq=1 with pq_inp_data=in_data, cnt++. If free, out_valid<=0.
  - In all three cases fair<=0.
- RUN, idle cycle: a consumed output (out_valid && out_ready) with no refill and no insert clears out_valid.
- Ties: equal values never swap; the held element stays.
- Fairness: fair forces at most one refill before an pending insert gets a slot. The output may go invalid for one cycle as a result. Inserts are never starved.
- Bypass is used only when cnt==0, so a value already in the heap is never overtaken.
- Full: cnt==CAP with no swap/bypass gives in_ready=0. A swap at cnt==CAP is not allowed; in_ready=0.
- Flush, entry: flush in RUN drops the output register (out_valid<=0) and enters FLUSH. in_ready=0 throughout FLUSH.
- Flush, drain: pq_deq=1 every cycle while cnt>0, cnt--.
- Flush, exit: at cnt==0, flush_done pulses for one cycle and the state returns to RUN. If cnt==0 at entry, flush_done pulses the next cycle.
- Flush, ignored: flush while already in FLUSH has no effect.
- Flush, precedence: flush has priority over a same-cycle insert or consume; the insert is not accepted.
- cnt_err: compared every cycle in which no pq op occurred on the previous cycle. Once set, it clears only on reset.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). The prio_q is reset by the same system reset.

Decomposition:
- Package prio_q_pkg holds: DWIDTH, HDEPTH, CAP, the state enum {RUN, FLUSH}, and an element-compare function (unsigned less-than).
- No sub-module. Arbitration, output register and mirror counter form one block of roughly 200 lines.

Test Plan:
- Bypass: empty, out_ready=0; insert 40 -> out_valid=1, out_data=40 next cycle, pq_enq never asserted, occupancy=1.
- Swap: holding 40, out_ready=0; insert 25 -> pq_enq=1 with pq_inp_data=40, out_data=25, cnt=1. Then insert 25 again -> pq_enq with data 25, no swap.
- Ordering: insert 50,10,30,20,40 with out_ready=0; then out_ready=1 every cycle -> outputs 10,20,30,40,50; pq_enq and pq_deq never high together.
- Fairness: heap holds 10 elements, out_ready=1 constantly, in_valid=1 with value 99 -> insert accepted within 2 cycles; 99 emerges last.
- Full: fill to occupancy 32 (31 in heap + 1 held) -> in_ready=0; insert smaller than the held value still refused; one pop re-enables in_ready.
- Flush: 7 in heap + 1 held, pulse flush -> 7 consecutive pq_deq cycles, flush_done one cycle later, occupancy=0. Assert rst mid-flush -> immediate reset values, cnt_err=0.
